// File: rtl/mul_pkg.sv
// Shared constants for the multiplier final-adder slice: default operand width,
// OpSel encodings and the per-segment width helper.
package mul_pkg;

  localparam int MUL_XLEN = 64;

  localparam logic MUL_SEL_LO = 1'b0;
  localparam logic MUL_SEL_HI = 1'b1;

  // Width of one final-adder slice for a 2*xlen-bit product split segs ways.
  function automatic int mul_seg_width(input int xlen, input int segs);
    return (2 * xlen) / segs;
  endfunction

endpackage

// File: rtl/mul_seg_adder.sv
// One combinational W-bit slice of the final adder: parallel-prefix
// (Kogge-Stone) carry network over generate/propagate pairs.
module mul_seg_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g, p, gg, pp, ng, np;
  logic [W:0]   c;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = g;
    pp = p;
    ng = '0;
    np = '0;
    for (int d = 1; d < W; d = d * 2) begin
      ng = gg;
      np = pp;
      for (int i = d; i < W; i++) begin
        ng[i] = gg[i] | (pp[i] & gg[i-d]);
        np[i] = pp[i] & pp[i-d];
      end
      gg = ng;
      pp = np;
    end
    // gg/pp[i] now span bits i..0; fold in the slice carry-in.
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      c[i+1] = gg[i] | (pp[i] & cin);
    end
    sum  = p ^ c[W-1:0];
    cout = c[W];
  end

endmodule

// File: rtl/mul_final_add_pipe.sv
// Pipelined final carry-propagate adder of the multiplier: SEGS slice stages,
// then product half selection. MUL_FINAL_OUTREG_EN adds a registered output stage.
module mul_final_add_pipe
  import mul_pkg::*;
#(
  parameter int XLEN = MUL_XLEN,
  parameter int SEGS = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2*XLEN-1:0] SumIn,
  input  logic [2*XLEN-1:0] CarryIn,
  input  logic              OpSel,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [XLEN-1:0]   Result,
  output logic              DonePulse
);

  localparam int P = 2 * XLEN;
  localparam int W = mul_seg_width(XLEN, SEGS);

  // Handshake: a transfer happens on an edge where valid && ready. The whole
  // pipe moves only when adv (output empty or taken); Flush blocks input and
  // drops every in-flight valid, and suppresses the output transfer.
  logic adv, take;

  // Stage k holds slices 0..k already summed in acc; slices above k are still
  // the raw sum vector, with the matching raw carry vector in car.
  logic [P-1:0]    acc_q [SEGS];
  logic [P-1:0]    acc_d [SEGS];
  logic [P-1:0]    car_q [SEGS];
  logic [P-1:0]    car_d [SEGS];
  logic            cy_q  [SEGS];
  logic            cy_d  [SEGS];
  logic [SEGS-1:0] v_q, v_d, op_q, op_d;

  logic [W-1:0] seg_a   [SEGS];
  logic [W-1:0] seg_b   [SEGS];
  logic [W-1:0] seg_sum [SEGS];
  logic         seg_ci  [SEGS];
  logic         seg_co  [SEGS];

  logic [XLEN-1:0] half_sel;
  logic            done_q, done_d;

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    if (k == 0) begin : g_first
      assign seg_a[k]  = SumIn[W-1:0];
      assign seg_b[k]  = CarryIn[W-1:0];
      assign seg_ci[k] = 1'b0;
    end else begin : g_next
      assign seg_a[k]  = acc_q[k-1][k*W +: W];
      assign seg_b[k]  = car_q[k-1][k*W +: W];
      assign seg_ci[k] = cy_q[k-1];
    end
    mul_seg_adder #(.W(W)) u_seg (
      .a    (seg_a[k]),
      .b    (seg_b[k]),
      .cin  (seg_ci[k]),
      .sum  (seg_sum[k]),
      .cout (seg_co[k])
    );
  end

  assign InReady = adv && !Flush;
  assign take    = InValid && InReady;

  always_comb begin
    acc_d = acc_q;
    car_d = car_q;
    cy_d  = cy_q;
    op_d  = op_q;
    v_d   = v_q;
    if (adv) begin
      acc_d[0]          = SumIn;
      acc_d[0][W-1:0]   = seg_sum[0];
      car_d[0]          = CarryIn;
      cy_d[0]           = seg_co[0];
      op_d[0]           = OpSel;
      v_d[0]            = take;
      for (int k = 1; k < SEGS; k++) begin
        acc_d[k]          = acc_q[k-1];
        acc_d[k][k*W +: W] = seg_sum[k];
        car_d[k]          = car_q[k-1];
        cy_d[k]           = seg_co[k];
        op_d[k]           = op_q[k-1];
        v_d[k]            = v_q[k-1];
      end
    end
    if (Flush) v_d = '0;
  end

  always_comb begin
    half_sel = (op_q[SEGS-1] == MUL_SEL_HI) ? acc_q[SEGS-1][P-1:XLEN]
                                            : acc_q[SEGS-1][XLEN-1:0];
    done_d   = OutValid && OutReady && !Flush;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      v_q    <= '0;
      done_q <= 1'b0;
    end else begin
      v_q    <= v_d;
      done_q <= done_d;
    end
    acc_q <= acc_d;
    car_q <= car_d;
    cy_q  <= cy_d;
    op_q  <= op_d;
  end

`ifdef MUL_FINAL_OUTREG_EN
  logic            out_v_q, out_v_d;
  logic [XLEN-1:0] res_q, res_d;

  assign adv = !out_v_q || OutReady;

  always_comb begin
    out_v_d = out_v_q;
    res_d   = res_q;
    if (adv) begin
      out_v_d = v_q[SEGS-1];
      res_d   = half_sel;
    end
    if (Flush) out_v_d = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) out_v_q <= 1'b0;
    else      out_v_q <= out_v_d;
    res_q <= res_d;
  end

  assign OutValid = out_v_q;
  assign Result   = res_q;
`else
  assign adv      = !v_q[SEGS-1] || OutReady;
  assign OutValid = v_q[SEGS-1];
  assign Result   = half_sel;
`endif

  assign DonePulse = done_q;

endmodule

// File: tb/tb_mul_final_add_pipe.sv
// Bench for mul_final_add_pipe: random and directed operations scored against
// a plain 2*XLEN-bit addition model; includes a SEGS=1 instance.
module tb_mul_final_add_pipe;
  import mul_pkg::*;

  localparam int XLEN = 64;
  localparam int SEGS = 4;
  localparam int P    = 2 * XLEN;
`ifdef MUL_FINAL_OUTREG_EN
  localparam int LAT  = SEGS + 1;
  localparam int LAT1 = 2;
`else
  localparam int LAT  = SEGS;
  localparam int LAT1 = 1;
`endif

  logic            Clk, Rst;
  logic            InValid, InReady, OpSel, Flush, OutValid, OutReady, DonePulse;
  logic [P-1:0]    SumIn, CarryIn;
  logic [XLEN-1:0] Result;

  logic            s1_in_valid, s1_in_ready, s1_op, s1_out_valid, s1_done;
  logic [P-1:0]    s1_sum, s1_car;
  logic [XLEN-1:0] s1_result;

  mul_final_add_pipe #(.XLEN(XLEN), .SEGS(SEGS)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .SumIn(SumIn), .CarryIn(CarryIn), .OpSel(OpSel), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
    .DonePulse(DonePulse)
  );

  mul_final_add_pipe #(.XLEN(XLEN), .SEGS(1)) dut_s1 (
    .Clk(Clk), .Rst(Rst), .InValid(s1_in_valid), .InReady(s1_in_ready),
    .SumIn(s1_sum), .CarryIn(s1_car), .OpSel(s1_op), .Flush(1'b0),
    .OutValid(s1_out_valid), .OutReady(1'b1), .Result(s1_result),
    .DonePulse(s1_done)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [XLEN-1:0] exp_q[$];
  int              acyc_q[$];
  int              lat_q[$];
  int              out_cyc_q[$];
  int              errors = 0;
  int              checks = 0;
  int              out_cnt = 0;
  int              done_cnt = 0;
  logic [XLEN-1:0] last_res = '0;
  logic            mon_en = 1'b0;
  logic            hs_prev = 1'b0;

  task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full-width sum modulo 2^(2*XLEN), then the requested half.
  function automatic logic [XLEN-1:0] model(input logic [P-1:0] s, input logic [P-1:0] c,
                                             input logic op);
    logic [P-1:0] full;
    full = s + c;
    return (op == MUL_SEL_HI) ? full[P-1:XLEN] : full[XLEN-1:0];
  endfunction

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic issue(input logic [P-1:0] s, input logic [P-1:0] c, input logic op);
    int n;
    n       = 0;
    InValid = 1'b1;
    SumIn   = s;
    CarryIn = c;
    OpSel   = op;
    @(negedge Clk);
    while (!InReady && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!InReady) begin
      check("issue_timeout", 1'b0, 1'b1);
    end else begin
      exp_q.push_back(model(s, c, op));
      acyc_q.push_back(cyc);
    end
    @(posedge Clk);
    #1;
    InValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic logic [P-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    #1;
    if (mon_en) begin
      check("done_pulse", DonePulse, hs_prev);
      if (DonePulse === 1'b1) done_cnt++;
      if (OutValid === 1'b1 && OutReady && !Flush && Rst) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          check("result", Result, exp_q.pop_front());
          lat_q.push_back(cyc - acyc_q.pop_front());
          out_cyc_q.push_back(cyc);
          out_cnt++;
          last_res = Result;
        end
      end
      hs_prev = (OutValid === 1'b1) && OutReady && !Flush && Rst;
      if (!Rst || Flush) begin
        exp_q.delete();
        acyc_q.delete();
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [XLEN-1:0] held;
    int              base, dbase, lat;
    bit              found;

    Rst = 1'b0; InValid = 1'b0; SumIn = '0; CarryIn = '0; OpSel = 1'b0;
    Flush = 1'b0; OutReady = 1'b1;
    s1_in_valid = 1'b0; s1_sum = '0; s1_car = '0; s1_op = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_outvalid", OutValid, 1'b0);
    check("reset_done", DonePulse, 1'b0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(negedge Clk);
    check("inready_after_reset", InReady, 1'b1);
    mon_en = 1'b1;
    @(posedge Clk); #1;

    // All-ones plus one in the low half: carry crosses every slice, top carry lost.
    lat_q.delete();
    issue({P{1'b1}}, 1, MUL_SEL_LO);
    idle(LAT + 2);
    check("ones_lo_count", lat_q.size(), 1);
    if (lat_q.size() > 0) check("ones_lo_latency", lat_q[0], LAT);
    check("ones_lo_result", last_res, 0);

    // Carry into the high half.
    lat_q.delete();
    issue({{XLEN{1'b0}}, {XLEN{1'b1}}}, 1, MUL_SEL_HI);
    idle(LAT + 2);
    check("half_cross_count", lat_q.size(), 1);
    check("half_cross_result", last_res, 1);

    // Eight back-to-back random operations.
    lat_q.delete();
    out_cyc_q.delete();
    dbase = done_cnt;
    for (int i = 0; i < 8; i++) issue(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    idle(LAT + 3);
    check("b2b_count", out_cyc_q.size(), 8);
    for (int i = 0; i < out_cyc_q.size(); i++) begin
      check("b2b_latency", lat_q[i], LAT);
      check("b2b_consecutive", out_cyc_q[i], out_cyc_q[0] + i);
    end
    check("b2b_done_pulses", done_cnt - dbase, 8);

    // Back-pressure: fill the pipe, hold it for five cycles.
    OutReady = 1'b0;
    base = out_cnt;
    for (int i = 0; i < LAT; i++) issue(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    @(negedge Clk);
    check("stall_outvalid", OutValid, 1'b1);
    check("stall_inready", InReady, 1'b0);
    held = Result;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("stall_inready_hold", InReady, 1'b0);
      check("stall_result_stable", Result, held);
      check("stall_outvalid_hold", OutValid, 1'b1);
    end
    @(posedge Clk); #1;
    OutReady = 1'b1;
    idle(LAT + 3);
    check("stall_drained", out_cnt - base, LAT);
    check("stall_queue_empty", exp_q.size(), 0);

    // Flush with three operations in flight and a competing input.
    base = out_cnt;
    for (int i = 0; i < 3; i++) issue(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    InValid = 1'b1; SumIn = rnd128(); CarryIn = rnd128(); Flush = 1'b1;
    @(negedge Clk);
    check("flush_inready", InReady, 1'b0);
    @(posedge Clk); #1;
    InValid = 1'b0; Flush = 1'b0;
    @(negedge Clk);
    check("flush_outvalid", OutValid, 1'b0);
    check("flush_done", DonePulse, 1'b0);
    @(posedge Clk); #1;
    idle(LAT + 3);
    check("flush_no_output", out_cnt - base, 0);

    // Flush while an output handshake is being offered.
    base = out_cnt;
    for (int i = 0; i < LAT + 1; i++) issue(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    Flush = 1'b1;
    @(negedge Clk);
    check("flush_hs_outvalid_before", OutValid, 1'b1);
    @(posedge Clk); #1;
    Flush = 1'b0;
    @(negedge Clk);
    check("flush_hs_done", DonePulse, 1'b0);
    check("flush_hs_outvalid", OutValid, 1'b0);
    @(posedge Clk); #1;
    idle(LAT + 3);
    check("flush_hs_outputs", out_cnt - base, 1);

    // Reset in the middle of a stream.
    for (int i = 0; i < LAT + 2; i++) issue(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    Rst = 1'b0;
    @(negedge Clk);
    check("midrst_outvalid_before", OutValid, 1'b1);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(negedge Clk);
    check("midrst_outvalid", OutValid, 1'b0);
    check("midrst_done", DonePulse, 1'b0);
    check("midrst_inready", InReady, 1'b1);
    @(posedge Clk); #1;
    base = out_cnt;
    idle(LAT + 3);
    check("midrst_no_output", out_cnt - base, 0);

    // Single-segment instance: one registered adder.
    for (int t = 0; t < 3; t++) begin
      logic [P-1:0]    s, c;
      logic            op;
      logic [XLEN-1:0] e;
      if (t == 0)      begin s = {P{1'b1}}; c = 1; op = MUL_SEL_LO; end
      else if (t == 1) begin s = {{XLEN{1'b0}}, {XLEN{1'b1}}}; c = 1; op = MUL_SEL_HI; end
      else             begin s = rnd128(); c = rnd128(); op = 1'($urandom_range(0, 1)); end
      e = model(s, c, op);
      s1_in_valid = 1'b1; s1_sum = s; s1_car = c; s1_op = op;
      found = 1'b0; lat = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
        @(posedge Clk); #1;
        s1_in_valid = 1'b0;
        @(negedge Clk);
        if (s1_out_valid) begin
          found = 1'b1;
          lat   = i;
          check("segs1_result", s1_result, e);
        end
      end
      check("segs1_latency", lat, LAT1);
      @(posedge Clk); #1;
      idle(2);
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
